// File: rtl/conv2_pkg.sv
// Shared constants, state encodings and helpers for the conv2 scheduler.
// Geometry here must match the window line buffer and MAC datapath it drives.
package conv2_pkg;

    localparam int IN_W   = 12;
    localparam int IN_H   = 12;
    localparam int K      = 5;
    localparam int NUM_OC = 12;

    localparam int OUT_W = IN_W - K + 1;
    localparam int OUT_H = IN_H - K + 1;

    localparam int IN_CW  = $clog2(IN_W);
    localparam int IN_RW  = $clog2(IN_H);
    localparam int OUT_CW = $clog2(OUT_W);
    localparam int OUT_RW = $clog2(OUT_H);
    localparam int OC_W   = $clog2(NUM_OC);

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t SCAN  = 2'd1;
    localparam state_t ISSUE = 2'd2;
    localparam state_t DONE  = 2'd3;

    // A window is complete once the buffer holds K full rows and K columns.
    function automatic logic window_ready(input logic [IN_CW-1:0] col,
                                          input logic [IN_RW-1:0] row);
        return (col >= IN_CW'(K - 1)) && (row >= IN_RW'(K - 1));
    endfunction

endpackage

// File: rtl/conv2_if.sv
// Handshake and result-tag bundle between the conv2 scheduler and its neighbours.
interface conv2_if;
    import conv2_pkg::*;

    logic              start;
    logic              pix_valid;
    logic              pix_ready;
    logic [OC_W-1:0]   oc_sel;
    logic              calc_valid;
    logic [OUT_CW-1:0] out_col;
    logic [OUT_RW-1:0] out_row;
    logic              pair_last;
    logic              row_last;
    logic              busy;
    logic              done;

    modport master (
        output start, pix_valid,
        input  pix_ready, oc_sel, calc_valid, out_col, out_row,
               pair_last, row_last, busy, done
    );

    modport slave (
        input  start, pix_valid,
        output pix_ready, oc_sel, calc_valid, out_col, out_row,
               pair_last, row_last, busy, done
    );

endinterface

// File: rtl/conv2_pos_cnt.sv
// Column/row raster counter: column wraps at W-1 and bumps the row, row wraps at H-1.
module conv2_pos_cnt #(
    parameter int W  = 12,
    parameter int H  = 12,
    parameter int CW = $clog2(W),
    parameter int RW = $clog2(H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          col_wrap,
    output logic          last
);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    always_comb begin
        col_wrap = (col_q == CW'(W - 1));
        last     = col_wrap && (row_q == RW'(H - 1));
        col      = col_q;
        row      = row_q;
    end

    // Clear has priority so a fresh frame always starts at the origin.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr) begin
            col_d = '0;
            row_d = '0;
        end else if (en) begin
            if (col_wrap) begin
                col_d = '0;
                row_d = last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/conv2_sched.sv
// conv2 sequencer: tracks pixel position, gates warm-up windows and
// time-shares the MAC datapath over NUM_OC output channels per valid window.
module conv2_sched
    import conv2_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    conv2_if.slave bus
);

    localparam logic [OC_W-1:0]   OC_LAST  = OC_W'(NUM_OC - 1);
    localparam logic [OUT_CW-1:0] COL_LAST = OUT_CW'(OUT_W - 1);
    localparam logic [OUT_RW-1:0] ROW_LAST = OUT_RW'(OUT_H - 1);

    state_t            state_q, state_d;
    logic [OC_W-1:0]   oc_q, oc_d;
    logic [OUT_CW-1:0] out_col_q, out_col_d;
    logic [OUT_RW-1:0] out_row_q, out_row_d;

    logic              cnt_clr;
    logic              cnt_en;
    logic              accept;
    logic [IN_CW-1:0]  in_col;
    logic [IN_RW-1:0]  in_row;
    logic              in_wrap;
    logic              in_last;
    logic              unused_pos_flags;

    assign unused_pos_flags = in_wrap ^ in_last;

    conv2_pos_cnt #(
        .W (IN_W),
        .H (IN_H)
    ) u_in_pos (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .col      (in_col),
        .row      (in_row),
        .col_wrap (in_wrap),
        .last     (in_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            oc_q      <= '0;
            out_col_q <= '0;
            out_row_q <= '0;
        end else begin
            state_q   <= state_d;
            oc_q      <= oc_d;
            out_col_q <= out_col_d;
            out_row_q <= out_row_d;
        end
    end

    assign accept = bus.pix_valid && (state_q == SCAN);

    // Next state and counter updates; out_col/out_row only move on a window accept.
    always_comb begin
        state_d   = state_q;
        oc_d      = oc_q;
        out_col_d = out_col_q;
        out_row_d = out_row_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SCAN;
                    cnt_clr = 1'b1;
                    oc_d    = '0;
                end
            end
            SCAN: begin
                if (accept) begin
                    cnt_en = 1'b1;
                    if (window_ready(in_col, in_row)) begin
                        out_col_d = OUT_CW'(in_col - IN_CW'(K - 1));
                        out_row_d = OUT_RW'(in_row - IN_RW'(K - 1));
                        oc_d      = '0;
                        state_d   = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (oc_q == OC_LAST) begin
                    oc_d    = '0;
                    state_d = ((out_row_q == ROW_LAST) && (out_col_q == COL_LAST)) ? DONE : SCAN;
                end else begin
                    oc_d = oc_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.pix_ready  = (state_q == SCAN);
        bus.calc_valid = (state_q == ISSUE);
        bus.oc_sel     = (state_q == ISSUE) ? oc_q : '0;
        bus.out_col    = out_col_q;
        bus.out_row    = out_row_q;
        bus.pair_last  = (state_q == ISSUE) && out_col_q[0];
        bus.row_last   = (state_q == ISSUE) && (out_col_q == COL_LAST);
        bus.busy       = (state_q != IDLE);
        bus.done       = (state_q == DONE);
    end

endmodule

// File: tb/tb_conv2_sched.sv
// Scoreboard bench for conv2_sched: expected channel bursts are queued per accepted
// window pixel and checked against every calc_valid cycle.
module tb_conv2_sched;
    import conv2_pkg::*;

    typedef struct packed {
        logic [3:0] oc;
        logic [3:0] col;
        logic [3:0] row;
        logic       pair;
        logic       rlast;
    } exp_t;

    logic clk;
    logic rst;
    conv2_if bus ();

    conv2_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];
    int   in_idx      = 0;
    int   accept_cnt  = 0;
    int   calc_cnt    = 0;
    int   done_cnt    = 0;
    int   busy_cyc    = 0;
    int   cyc         = 0;
    int   win_acc_cyc = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor samples mid-cycle; inputs change just after the rising edge.
    always @(negedge clk) begin
        exp_t e;
        int   c;
        int   r;
        cyc++;
        if (!rst) begin
            if (bus.busy && !bus.done) busy_cyc++;
            if (bus.done) done_cnt++;
            if (bus.pix_valid && bus.pix_ready) begin
                accept_cnt++;
                c = in_idx % IN_W;
                r = in_idx / IN_W;
                if (c >= K - 1 && r >= K - 1) begin
                    win_acc_cyc = cyc;
                    for (int o = 0; o < NUM_OC; o++) begin
                        e.oc    = 4'(o);
                        e.col   = 4'(c - (K - 1));
                        e.row   = 4'(r - (K - 1));
                        e.pair  = e.col[0];
                        e.rlast = (c - (K - 1)) == OUT_W - 1;
                        sb.push_back(e);
                    end
                end
                in_idx = (in_idx + 1) % (IN_W * IN_H);
            end
            if (bus.calc_valid) begin
                if (calc_cnt == 0) checkOutput("warmup_accepts", accept_cnt, 53);
                calc_cnt++;
                checkOutput("ready_in_issue", 32'(bus.pix_ready), 0);
                if (sb.size() == 0) begin
                    checkOutput("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    if (e.oc == 0) checkOutput("latency", cyc - win_acc_cyc, 1);
                    checkOutput("oc_sel",    32'(bus.oc_sel),    32'(e.oc));
                    checkOutput("out_col",   32'(bus.out_col),   32'(e.col));
                    checkOutput("out_row",   32'(bus.out_row),   32'(e.row));
                    checkOutput("pair_last", 32'(bus.pair_last), 32'(e.pair));
                    checkOutput("row_last",  32'(bus.row_last),  32'(e.rlast));
                end
            end else begin
                checkOutput("oc_sel_idle", 32'(bus.oc_sel), 0);
            end
        end
    end

    task automatic clearFrame();
        sb.delete();
        in_idx     = 0;
        accept_cnt = 0;
        calc_cnt   = 0;
        done_cnt   = 0;
        busy_cyc   = 0;
    endtask

    task automatic pulseStart();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic checkZeroOutputs(input string tag);
        checkOutput({tag, "_ready"}, 32'(bus.pix_ready),  0);
        checkOutput({tag, "_calc"},  32'(bus.calc_valid), 0);
        checkOutput({tag, "_oc"},    32'(bus.oc_sel),     0);
        checkOutput({tag, "_col"},   32'(bus.out_col),    0);
        checkOutput({tag, "_row"},   32'(bus.out_row),    0);
        checkOutput({tag, "_pair"},  32'(bus.pair_last),  0);
        checkOutput({tag, "_rlast"}, 32'(bus.row_last),   0);
        checkOutput({tag, "_busy"},  32'(bus.busy),       0);
        checkOutput({tag, "_done"},  32'(bus.done),       0);
    endtask

    task automatic applyStimulus(input bit gaps, input bit poke);
        bit seen;
        seen = 1'b0;
        clearFrame();
        pulseStart();
        for (int n = 0; n < 8000 && !seen; n++) begin
            bus.pix_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.start     = poke && (n == 300);
            @(posedge clk); #1;
            if (bus.done) seen = 1'b1;
        end
        bus.start = poke;
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.pix_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("frame_done_seen", 32'(seen), 1);
        checkOutput("accepts",   accept_cnt, 144);
        checkOutput("calc_cnt",  calc_cnt, 768);
        checkOutput("done_cnt",  done_cnt, 1);
        checkOutput("sb_left",   sb.size(), 0);
        checkOutput("busy_after", 32'(bus.busy), 0);
        if (!gaps) checkOutput("frame_cycles", busy_cyc, 912);
    endtask

    task automatic abortFrame();
        bit hit;
        hit = 1'b0;
        clearFrame();
        pulseStart();
        bus.pix_valid = 1'b1;
        for (int n = 0; n < 2000 && !hit; n++) begin
            @(posedge clk); #1;
            if (bus.calc_valid && bus.oc_sel == 4 && bus.out_col == 2) hit = 1'b1;
        end
        checkOutput("abort_reached", 32'(hit), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        checkZeroOutputs("abort");
        rst           = 1'b0;
        bus.pix_valid = 1'b0;
        done_cnt      = 0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("abort_no_done", done_cnt, 0);
        checkOutput("abort_idle", 32'(bus.busy), 0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.pix_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkZeroOutputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] continuous stream frame");
        applyStimulus(1'b0, 1'b0);
        $display("[TB] random gap frame");
        applyStimulus(1'b1, 1'b0);
        $display("[TB] reset during ISSUE");
        abortFrame();
        $display("[TB] full frame after reset");
        applyStimulus(1'b0, 1'b0);
        $display("[TB] start pulses while busy and in DONE");
        applyStimulus(1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
